alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the branch/address unit.
- Arbitrates round-robin, registers the winning operands onto the ALU inputs, and captures the ALU result and zero flag.
- Returns the captured result on the winner's response channel, using a valid/ready handshake.
- Screens control codes before issue; illegal codes never reach the ALU.

---
 rtl/alu_share_arbiter_if.sv | 54 +++++
 rtl/alu_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester channels, the shared ALU connection, the two response
// channels and the grant counters of alu_share_arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              req0_valid, req0_ready;
  logic [WIDTH-1:0]  req0_in1, req0_in2;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [TAG_W-1:0]  req0_tag;
  logic              req1_valid, req1_ready;
  logic [WIDTH-1:0]  req1_in1, req1_in2;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [TAG_W-1:0]  req1_tag;

  logic [WIDTH-1:0]  alu_in1, alu_in2, alu_out;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_zero;

  logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic [WIDTH-1:0]  rsp0_result;
  logic [TAG_W-1:0]  rsp0_tag;
  logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [WIDTH-1:0]  rsp1_result;
  logic [TAG_W-1:0]  rsp1_tag;

  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_ctrl, req0_tag,
    input  req1_valid, req1_in1, req1_in2, req1_ctrl, req1_tag,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_ctrl,
    input  alu_out, alu_zero,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, rsp0_tag,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, rsp1_tag,
    input  rsp0_ready, rsp1_ready,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_ctrl, req0_tag,
    output req1_valid, req1_in1, req1_in2, req1_ctrl, req1_tag,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_ctrl,
    output alu_out, alu_zero,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err, rsp0_tag,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, rsp1_tag,
    output rsp0_ready, rsp1_ready,
    input  grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute stage (port 0) and the
// branch/address unit (port 1); illegal control codes are answered without touching the ALU.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  alu_share_arbiter_if.slave bus
);
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  localparam logic [CTRL_W-1:0] CtrlAdd = CTRL_W'(6'b100000);

  function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
    logic ok;
    case (c)
      6'b100000, 6'b100001, 6'b100100, 6'b100101, 6'b100110, 6'b100010, 6'b100011,
      6'b000000, 6'b000100, 6'b000011, 6'b000010, 6'b000110, 6'b101010, 6'b101011,
      6'b001000, 6'b111000, 6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
      6'b110101: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [1:0]             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   win_q, win_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [WIDTH-1:0]       alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [CTRL_W-1:0]      alu_ctrl_q, alu_ctrl_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [1:0][WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [1:0][TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [1:0][CNT_W-1:0]  grant_cnt_q, grant_cnt_d;

  logic [1:0]        req_valid, rsp_ready;
  logic              accept, grant, sel_legal;
  logic [WIDTH-1:0]  sel_in1, sel_in2;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [TAG_W-1:0]  sel_tag;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign accept    = (state_q == StIdle) && (req_valid != 2'b00);
  // On contention the port that did not win last time goes first.
  assign grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign sel_in1   = grant ? bus.req1_in1  : bus.req0_in1;
  assign sel_in2   = grant ? bus.req1_in2  : bus.req0_in2;
  assign sel_ctrl  = grant ? bus.req1_ctrl : bus.req0_ctrl;
  assign sel_tag   = grant ? bus.req1_tag  : bus.req0_tag;
  assign sel_legal = ctrl_legal(sel_ctrl);

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    tag_d        = tag_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    grant_cnt_d  = grant_cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d       = grant;
          win_d              = grant;
          tag_d              = sel_tag;
          grant_cnt_d[grant] = grant_cnt_q[grant] + CNT_W'(1);
          if (sel_legal) begin
            alu_in1_d  = sel_in1;
            alu_in2_d  = sel_in2;
            alu_ctrl_d = sel_ctrl;
            state_d    = StIssue;
          end else begin
            // Illegal code: answer straight away, ALU inputs keep the previous op.
            rsp_valid_d[grant]  = 1'b1;
            rsp_result_d[grant] = '0;
            rsp_zero_d[grant]   = 1'b0;
            rsp_err_d[grant]    = 1'b1;
            rsp_tag_d[grant]    = sel_tag;
            state_d             = StResp;
          end
        end
      end
      StIssue: begin
        rsp_valid_d[win_q]  = 1'b1;
        rsp_result_d[win_q] = bus.alu_out;
        rsp_zero_d[win_q]   = bus.alu_zero;
        rsp_err_d[win_q]    = 1'b0;
        rsp_tag_d[win_q]    = tag_q;
        state_d             = StResp;
      end
      StResp: begin
        if (rsp_ready[win_q]) begin
          rsp_valid_d[win_q] = 1'b0;
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      tag_q        <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_ctrl_q   <= CtrlAdd;
      rsp_valid_q  <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      grant_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      tag_q        <= tag_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign bus.alu_in1     = alu_in1_q;
  assign bus.alu_in2     = alu_in2_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp0_zero   = rsp_zero_q[0];
  assign bus.rsp0_err    = rsp_err_q[0];
  assign bus.rsp0_tag    = rsp_tag_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp1_zero   = rsp_zero_q[1];
  assign bus.rsp1_err    = rsp_err_q[1];
  assign bus.rsp1_tag    = rsp_tag_q[1];
  assign bus.grant_cnt0  = grant_cnt_q[0];
  assign bus.grant_cnt1  = grant_cnt_q[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: drivers push expected responses on accept, a
// negedge monitor checks grants and responses against an abstract arbitration model.
module tb_alu_share_arbiter;
  typedef struct packed {
    logic [31:0] res;
    logic        z;
  } alu_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  typedef struct {
    int   port;
    rsp_t r;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] legal_codes [22] = '{
    6'b100000, 6'b100001, 6'b100100, 6'b100101, 6'b100110, 6'b100010, 6'b100011, 6'b000000,
    6'b000100, 6'b000011, 6'b000010, 6'b000110, 6'b101010, 6'b101011, 6'b001000, 6'b111000,
    6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100, 6'b110101
  };

  int   n_chk = 0;
  int   n_pass = 0;
  ent_t exp_q[$];
  int   grant_log[$];
  logic busy = 1'b0;
  logic exp_last = 1'b1;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;
  logic rand_done = 1'b0;

  // Behaviour of the external ALU, also used to predict responses.
  function automatic alu_t alu_ref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_t o;
    o.res = '0;
    o.z   = 1'b0;
    case (c)
      6'b100000, 6'b100001: o.res = a + b;
      6'b100010, 6'b100011: o.res = a - b;
      6'b100100:            o.res = a & b;
      6'b100101:            o.res = a | b;
      6'b100110:            o.res = a ^ b;
      6'b000000, 6'b000100: o.res = b << a[4:0];
      6'b000010, 6'b000110: o.res = b >> a[4:0];
      6'b000011:            o.res = 32'($signed(b) >>> a[4:0]);
      6'b101010:            o.res = {31'd0, $signed(a) < $signed(b)};
      6'b101011:            o.res = {31'd0, a < b};
      6'b001000:            o.res = a;
      6'b111000:            o.res = ~(a | b);
      default:              o.res = '0;
    endcase
    case (c)
      6'b110000: o.z = (a == b);
      6'b110001: o.z = (a != b);
      6'b110010: o.z = ($signed(a) <  $signed(b));
      6'b110011: o.z = ($signed(a) >= $signed(b));
      6'b110100: o.z = ($signed(a) >  $signed(b));
      6'b110101: o.z = ($signed(a) <= $signed(b));
      default:   o.z = (o.res == 32'd0);
    endcase
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] c);
    logic ok = 1'b0;
    foreach (legal_codes[i]) if (legal_codes[i] == c) ok = 1'b1;
    return ok;
  endfunction

  function automatic rsp_t expect_rsp(input logic [31:0] a, input logic [31:0] b,
                                      input logic [5:0] c, input logic [3:0] t);
    alu_t x;
    if (!is_legal(c)) return {32'd0, 1'b0, 1'b1, t};
    x = alu_ref(c, a, b);
    return {x.res, x.z, 1'b0, t};
  endfunction

  assign {bus.alu_out, bus.alu_zero} = alu_ref(bus.alu_ctrl, bus.alu_in1, bus.alu_in2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c, input logic [3:0] t);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_ctrl = c; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_ctrl = c; bus.req1_tag = t;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] c, input logic [3:0] t);
    ent_t e;
    logic got = 1'b0;
    set_req(p, 1'b1, a, b, c, t);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_timeout", 64'(got), 64'd1);
    if (got) begin
      e.port = p;
      e.r    = expect_rsp(a, b, c, t);
      exp_q.push_back(e);
    end
    step();
    set_req(p, 1'b0, a, b, c, t);
  endtask

  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !bus.rsp0_valid && !bus.rsp1_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
    step();
  endtask

  task automatic rand_ops(input int p, input int n);
    logic [31:0] a, b;
    logic [5:0]  c;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      c = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_codes[$urandom_range(0, 21)];
      issue(p, a, b, c, 4'($urandom));
    end
  endtask

  // Monitor: response scoreboard plus an abstract round-robin grant model.
  always @(negedge clk) begin
    logic [1:0] rv, rq, vv, rr;
    rsp_t       act [2];
    ent_t       e;
    logic       exp_w;
    rv = {bus.rsp1_valid, bus.rsp0_valid};
    rq = {bus.req1_ready, bus.req0_ready};
    vv = {bus.req1_valid, bus.req0_valid};
    rr = {bus.rsp1_ready, bus.rsp0_ready};
    act[0] = {bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err, bus.rsp0_tag};
    act[1] = {bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err, bus.rsp1_tag};
    if (reset) begin
      exp_q.delete();
      busy     = 1'b0;
      exp_last = 1'b1;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
    end else begin
      if (rv != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rv), 64'd0);
        end else begin
          e = exp_q[0];
          chk("rsp_port", 64'(rv), (e.port == 1) ? 64'd2 : 64'd1);
          chk("rsp_data", 64'(act[e.port]), 64'(e.r));
          if (rr[e.port]) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
      end
      if (rq != 2'b00) begin
        exp_w = (vv == 2'b11) ? ~exp_last : vv[1];
        chk("ready_has_valid", 64'(rq & ~vv), 64'd0);
        chk("ready_winner", 64'(rq), exp_w ? 64'd2 : 64'd1);
        chk("ready_when_idle", 64'(busy), 64'd0);
        exp_last = rq[1];
        if (rq[1]) exp_cnt1++;
        else exp_cnt0++;
        grant_log.push_back(int'(rq[1]));
        busy = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(0, 1'b0, 32'd0, 32'd0, 6'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'd0, 4'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'h20);
    chk("rst_alu_in", {bus.alu_in1, bus.alu_in2}, 64'd0);
    chk("rst_rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
    chk("rst_rsp0", 64'({bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err, bus.rsp0_tag}), 64'd0);
    chk("rst_cnt", 64'({bus.grant_cnt1, bus.grant_cnt0}), 64'd0);
    step();
    reset = 1'b0;

    // Single ADD on port 0.
    issue(0, 32'd5, -32'sd7, 6'b100000, 4'd3);
    @(negedge clk);
    chk("single_alu_ctrl", 64'(bus.alu_ctrl), 64'h20);
    chk("single_alu_in2", 64'(bus.alu_in2), 64'hFFFF_FFF9);
    chk("single_no_early_rsp", 64'(bus.rsp0_valid), 64'd0);
    @(negedge clk);
    chk("single_rsp_valid", 64'(bus.rsp0_valid), 64'd1);
    chk("single_result", 64'(bus.rsp0_result), 64'hFFFF_FFFE);
    chk("single_tag_err", 64'({bus.rsp0_tag, bus.rsp0_err}), 64'h6);
    wait_idle("single_idle");
    chk("single_cnt0", 64'(bus.grant_cnt0), 64'd1);

    // Branch compare on port 1.
    issue(1, 32'd9, 32'd9, 6'b110000, 4'd5);
    repeat (2) @(negedge clk);
    chk("beq_zero", 64'(bus.rsp1_zero), 64'd1);
    chk("beq_result", 64'(bus.rsp1_result), 64'd0);
    wait_idle("beq_idle");
    issue(1, 32'd9, 32'd9, 6'b110001, 4'd6);
    repeat (2) @(negedge clk);
    chk("bne_zero", 64'(bus.rsp1_zero), 64'd0);
    wait_idle("bne_idle");

    // Illegal code answers one cycle after accept and leaves the ALU alone.
    issue(0, 32'd1, 32'd2, 6'b111111, 4'd7);
    @(negedge clk);
    chk("illegal_valid_err", 64'({bus.rsp0_valid, bus.rsp0_err}), 64'd3);
    chk("illegal_result", 64'(bus.rsp0_result), 64'd0);
    chk("illegal_alu_ctrl", 64'(bus.alu_ctrl), 64'h31);
    chk("illegal_alu_in1", 64'(bus.alu_in1), 64'd9);
    wait_idle("illegal_idle");

    // Backpressure on port 0 while port 1 waits.
    bus.rsp0_ready = 1'b0;
    issue(0, 32'd100, 32'd23, 6'b100010, 4'd9);
    fork
      issue(1, 32'd7, 32'd8, 6'b100100, 4'd2);
    join_none
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.rsp0_valid), 64'd1);
      chk("bp_hold_result", 64'(bus.rsp0_result), 64'd77);
      chk("bp_no_req1_ready", 64'(bus.req1_ready), 64'd0);
    end
    step();
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_no_ready", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    chk("bp_req1_ready", 64'(bus.req1_ready), 64'd1);
    wait fork;
    wait_idle("bp_idle");

    // Reset while an op is in ISSUE.
    issue(0, 32'd3, 32'd4, 6'b100100, 4'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_issue_alu_ctrl", 64'(bus.alu_ctrl), 64'h20);
    chk("rst_issue_cnt0", 64'(bus.grant_cnt0), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_issue_no_rsp", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
    end
    step();

    // Contention straight after reset: grants alternate starting with port 0.
    grant_log.delete();
    fork
      begin
        issue(0, 32'd1, 32'd2, 6'b100000, 4'd1);
        issue(0, 32'd3, 32'd4, 6'b100001, 4'd2);
      end
      begin
        issue(1, 32'd5, 32'd6, 6'b100010, 4'd3);
        issue(1, 32'd7, 32'd8, 6'b100100, 4'd4);
      end
    join
    wait_idle("cont_idle");
    chk("cont_len", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("cont_order", 64'(grant_log[i]), 64'(i % 2));
    chk("cont_cnt0", 64'(bus.grant_cnt0), 64'd2);
    chk("cont_cnt1", 64'(bus.grant_cnt1), 64'd2);

    // Random traffic with random response backpressure.
    fork
      begin
        fork
          rand_ops(0, 40);
          rand_ops(1, 40);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          bus.rsp0_ready = ($urandom_range(0, 9) < 7);
          bus.rsp1_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    wait_idle("rand_idle");
    chk("rand_cnt0", 64'(bus.grant_cnt0), 64'(exp_cnt0));
    chk("rand_cnt1", 64'(bus.grant_cnt1), 64'(exp_cnt1));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
